rr_free_list_ckpt: RTL

Physical-register free list for the rename stage, built as a circular FIFO of free preg indices.
- Allocate: up to ALLOC_WIDTH pregs per cycle, all-or-nothing per group.
- Release: up to RELEASE_WIDTH pregs per cycle, driven by commit of the previous mapping (ppreg).
- Checkpoint/recover: C_NUM head-pointer checkpoints for single-cycle branch recovery.
- Generalises the fixed-width rename free pool with configurable widths, sparse request masks and checkpoint restore.

---
 rtl/rr_free_list_ckpt_pkg.sv | 40 ++++
 rtl/rr_free_list_ckpt_prefix_popcount.sv | 35 +++
 rtl/rr_free_list_ckpt.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_free_list_ckpt_pkg.sv
// rr_pkg
// Shared constants, derived widths and the checkpoint record for the
// rename-stage physical-register free list.
//
// Contents:
//   P_REGISTERS / L_REGISTERS  physical and logical register counts
//   INSTR_COUNT                default rename group width (allocation lanes)
//   C_NUM                      number of head-pointer checkpoint slots
//   FL_DEPTH                   free-list depth (pregs not holding the reset map)
//   PREG_W                     width of a physical register index
//   FL_PTR_W                   free-list pointer width (index plus wrap bit)
//   fl_ckpt_s                  one checkpoint slot: saved head plus valid flag
//   is_pow2()                  constant helper used for elaboration checks

package rr_pkg;

    localparam int P_REGISTERS = 64;
    localparam int L_REGISTERS = 32;
    localparam int INSTR_COUNT = 8;
    localparam int C_NUM       = 4;

    localparam int FL_DEPTH = P_REGISTERS - L_REGISTERS;
    localparam int PREG_W   = $clog2(P_REGISTERS);
    localparam int FL_PTR_W = $clog2(FL_DEPTH) + 1;

    // A checkpoint remembers only the head pointer: the tail keeps moving
    // forward with commits, so restoring head alone is enough to hand the
    // squashed allocations back to the pool.
    typedef struct packed {
        logic [FL_PTR_W-1:0] head;
        logic                valid;
    } fl_ckpt_s;

    // The pointer arithmetic relies on natural wrap-around, so the depth
    // has to be a power of two (and at least two so an index bit exists).
    function automatic logic is_pow2(input int value);
        return (value > 1) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/rr_free_list_ckpt_prefix_popcount.sv
// rr_prefix_popcount
// Per-lane exclusive prefix popcount of a request mask. Lane i receives the
// number of set bits strictly below it, which is that lane's offset into a
// compacted list. The total popcount is also provided.
//
// Ports:
//   mask    in   WIDTH                         lane mask
//   prefix  out  WIDTH x $clog2(WIDTH+1)       popcount(mask[i-1:0]) per lane
//   total   out  $clog2(WIDTH+1)               popcount(mask)

module rr_prefix_popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]                         mask,
    output logic [WIDTH-1:0][$clog2(WIDTH+1)-1:0]    prefix,
    output logic [$clog2(WIDTH+1)-1:0]               total
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Ripple a running count across the lanes. Each lane sees the count
    // before its own bit is added, giving an exclusive prefix; the widths
    // involved are small enough that a linear chain is acceptable.
    always_comb begin
        logic [CNT_W-1:0] acc;
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prefix[i] = acc;
            acc       = acc + CNT_W'(mask[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/rr_free_list_ckpt.sv
// rr_free_list_ckpt
// Physical-register free list for the rename stage. Free preg indices live in
// a circular FIFO; rename pulls a whole group of them per cycle from head,
// commit pushes previous mappings back at tail, and branch checkpoints save
// head so a mispredict can return every younger allocation in one cycle.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   alloc_valid     a rename group is present this cycle
//   alloc_req       lanes of the group that need a destination preg
//   alloc_grant     the whole group was allocated (all-or-nothing)
//   alloc_preg      preg handed to each requesting lane (same cycle)
//   release_en      commit lanes returning a preg
//   release_preg    preg index returned by each release lane
//   ckpt_take       save head (after this cycle's grant) into slot ckpt_id
//   ckpt_id         slot written by ckpt_take
//   ckpt_clear      invalidate slot ckpt_clear_id
//   ckpt_clear_id   slot dropped by ckpt_clear
//   recover_en      restore head from slot recover_id
//   recover_id      slot used by recover_en
//   free_count      number of free pregs currently held
//   ckpt_valid      per-slot valid flags
//   recover_err     one-cycle pulse after a recover of an invalid slot

module rr_free_list_ckpt #(
    parameter int P_REGISTERS   = rr_pkg::P_REGISTERS,
    parameter int L_REGISTERS   = rr_pkg::L_REGISTERS,
    parameter int ALLOC_WIDTH   = rr_pkg::INSTR_COUNT,
    parameter int RELEASE_WIDTH = rr_pkg::INSTR_COUNT,
    parameter int C_NUM         = rr_pkg::C_NUM,
    parameter int FL_DEPTH      = P_REGISTERS - L_REGISTERS
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            alloc_valid,
    input  logic [ALLOC_WIDTH-1:0]                          alloc_req,
    output logic                                            alloc_grant,
    output logic [ALLOC_WIDTH-1:0][$clog2(P_REGISTERS)-1:0] alloc_preg,
    input  logic [RELEASE_WIDTH-1:0]                        release_en,
    input  logic [RELEASE_WIDTH-1:0][$clog2(P_REGISTERS)-1:0] release_preg,
    input  logic                                            ckpt_take,
    input  logic [$clog2(C_NUM)-1:0]                        ckpt_id,
    input  logic                                            ckpt_clear,
    input  logic [$clog2(C_NUM)-1:0]                        ckpt_clear_id,
    input  logic                                            recover_en,
    input  logic [$clog2(C_NUM)-1:0]                        recover_id,
    output logic [$clog2(FL_DEPTH):0]                       free_count,
    output logic [C_NUM-1:0]                                ckpt_valid,
    output logic                                            recover_err
);

    import rr_pkg::*;

    localparam int PREG_BITS = $clog2(P_REGISTERS);
    localparam int IDX_W     = $clog2(FL_DEPTH);
    localparam int PTR_W     = IDX_W + 1;
    localparam int CID_W     = $clog2(C_NUM);
    localparam int ACNT_W    = $clog2(ALLOC_WIDTH + 1);
    localparam int RCNT_W    = $clog2(RELEASE_WIDTH + 1);

    // The circular-pointer scheme breaks for non power-of-two depths, and
    // the checkpoint record layout is shared through the package, so both
    // are rejected at elaboration rather than silently misbehaving.
    if (!is_pow2(FL_DEPTH)) begin : g_depth_check
        $error("rr_free_list_ckpt: FL_DEPTH must be a power of two");
    end
    if (PTR_W != FL_PTR_W) begin : g_ptr_check
        $error("rr_free_list_ckpt: pointer width differs from rr_pkg::FL_PTR_W");
    end

    logic [PREG_BITS-1:0] entry [FL_DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    fl_ckpt_s             ckpt [C_NUM];

    logic [ALLOC_WIDTH-1:0][ACNT_W-1:0]   alloc_prefix;
    logic [ACNT_W-1:0]                    alloc_n;
    logic [RELEASE_WIDTH-1:0][RCNT_W-1:0] rel_prefix;
    logic [RCNT_W-1:0]                    rel_n;

    logic             recover_ok;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;

    // Both compaction paths share the same prefix-count block: on the alloc
    // side it tells each requesting lane how far past head its preg sits,
    // on the release side how far past tail each returned preg is written.
    rr_prefix_popcount #(
        .WIDTH (ALLOC_WIDTH)
    ) u_alloc_count (
        .mask   (alloc_req),
        .prefix (alloc_prefix),
        .total  (alloc_n)
    );

    rr_prefix_popcount #(
        .WIDTH (RELEASE_WIDTH)
    ) u_release_count (
        .mask   (release_en),
        .prefix (rel_prefix),
        .total  (rel_n)
    );

    // Occupancy is the modular pointer distance; the extra wrap bit is what
    // separates a full list (distance FL_DEPTH) from an empty one (zero).
    assign free_count = tail - head;

    assign recover_ok = recover_en & ckpt[recover_id].valid;

    // A group is granted only when every requesting lane can be served.
    // Recovery owns the head pointer in its cycle, so allocation waits.
    assign alloc_grant = alloc_valid & ~recover_en & ~rst
                       & (32'(alloc_n) <= 32'(free_count));

    // Each requesting lane reads the entry at head plus its compacted
    // offset. Lanes that are not requesting still produce a value, which
    // the renamer ignores.
    always_comb begin
        logic [IDX_W-1:0] rd_idx;
        alloc_preg = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            rd_idx        = IDX_W'(head[IDX_W-1:0] + IDX_W'(alloc_prefix[i]));
            alloc_preg[i] = entry[rd_idx];
        end
    end

    // Head after this cycle's allocation; this is also the value a
    // checkpoint captures, so the branch's own group stays allocated after
    // a later recovery.
    assign head_next = alloc_grant ? head + PTR_W'(alloc_n) : head;
    assign tail_next = tail + PTR_W'(rel_n);

    // Pointer update. A valid recovery overrides the alloc path (which is
    // blocked anyway); a recovery of an invalid slot leaves head alone.
    // Commits keep moving tail regardless of what head is doing.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= PTR_W'(FL_DEPTH);
        end else begin
            if (recover_ok) begin
                head <= ckpt[recover_id].head;
            end else begin
                head <= head_next;
            end
            tail <= tail_next;
        end
    end

    // FIFO storage. Reset loads the pregs that are not part of the initial
    // architectural mapping. Released pregs are compacted in lane order and
    // written at consecutive slots starting at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry[i] <= PREG_BITS'(L_REGISTERS + i);
            end
        end else begin
            for (int i = 0; i < RELEASE_WIDTH; i++) begin
                if (release_en[i]) begin
                    entry[IDX_W'(tail[IDX_W-1:0] + IDX_W'(rel_prefix[i]))] <= release_preg[i];
                end
            end
        end
    end

    // Checkpoint slots. A take and a clear aimed at the same slot resolve in
    // favour of the take, since the new branch needs the slot. A take in a
    // recovery cycle is dropped: the snapshot would belong to a squashed path.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < C_NUM; s++) begin
                ckpt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < C_NUM; s++) begin
                if (ckpt_take && !recover_en && ckpt_id == CID_W'(s)) begin
                    ckpt[s].head  <= head_next;
                    ckpt[s].valid <= 1'b1;
                end else if (ckpt_clear && ckpt_clear_id == CID_W'(s)) begin
                    ckpt[s].valid <= 1'b0;
                end
            end
        end
    end

    // Recovering from a slot that holds nothing is a control-logic bug
    // upstream; flag it for one cycle instead of corrupting head.
    always_ff @(posedge clk) begin
        if (rst) begin
            recover_err <= 1'b0;
        end else begin
            recover_err <= recover_en & ~ckpt[recover_id].valid;
        end
    end

    always_comb begin
        for (int s = 0; s < C_NUM; s++) begin
            ckpt_valid[s] = ckpt[s].valid;
        end
    end

    // Occupancy after this cycle, used only to catch commits returning more
    // pregs than the list can hold (a double free upstream).
    logic [PTR_W-1:0] count_base;
    logic [31:0]      count_after;

    always_comb begin
        count_base  = recover_ok ? tail - ckpt[recover_id].head : free_count;
        count_after = 32'(count_base)
                    - (alloc_grant ? 32'(alloc_n) : 32'd0)
                    + 32'(rel_n);
    end

    assert property (@(posedge clk) disable iff (rst) count_after <= 32'(FL_DEPTH));

endmodule
